// File: rtl/cnn_ctrl_pkg.sv
// Shared types and width helpers for the CNN line-buffer controller.
package cnn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Counter widths never collapse to zero bits, even for a modulus of 1.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int IMG_WIDTH_DEF  = 28;
  localparam int IMG_HEIGHT_DEF = 28;
  localparam int KERNEL_DEF     = 3;

  localparam int COL_W = clog2_min1(IMG_WIDTH_DEF);
  localparam int ROW_W = clog2_min1(IMG_HEIGHT_DEF);
  localparam int IDX_W = clog2_min1(KERNEL_DEF);

endpackage

// File: rtl/line_buffer_controller_if.sv
// Pixel-side handshake and row-buffer control bundle of the line-buffer controller.
interface line_buffer_controller_if #(
  parameter int IMG_WIDTH = 28,
  parameter int KERNEL    = 3
);
  import cnn_ctrl_pkg::*;

  localparam int COL_BITS = clog2_min1(IMG_WIDTH);
  localparam int IDX_BITS = clog2_min1(KERNEL);

  logic                data_valid;
  logic [KERNEL-1:0]   buf_wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  logic [IDX_BITS-1:0] rd_top_idx;
  logic                rd_en;
  logic [COL_BITS-1:0] col_addr;
  logic                window_valid;
  logic                frame_done;

  modport master (
    output data_valid,
    input  buf_wr_en, wr_idx, rd_top_idx, rd_en, col_addr, window_valid, frame_done
  );

  modport slave (
    input  data_valid,
    output buf_wr_en, wr_idx, rd_top_idx, rd_en, col_addr, window_valid, frame_done
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-MOD counter with explicit compare-and-clear wrap, so any modulus works.
module wrap_counter #(
  parameter int MOD = 2,
  parameter int W   = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = (count == LAST);

  // Count register: clear wins over increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (en) begin
      count <= wrap ? {W{1'b0}} : count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/line_buffer_controller.sv
// Sequences KERNEL row buffers: column/row counting, write steering, read enables
// and window/frame status for the convolution window generator.
module line_buffer_controller
  import cnn_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int KERNEL     = 3
) (
  input logic                     clock,
  input logic                     reset,
  line_buffer_controller_if.slave bus
);

  localparam int COL_BITS = clog2_min1(IMG_WIDTH);
  localparam int ROW_BITS = clog2_min1(IMG_HEIGHT);
  localparam int IDX_BITS = clog2_min1(KERNEL);

  localparam logic [ROW_BITS-1:0] ROW_FILL_LAST = ROW_BITS'(KERNEL - 2);
  localparam logic [COL_BITS-1:0] COL_FIRST_WIN = COL_BITS'(KERNEL - 1);

  logic [COL_BITS-1:0] col_r;
  logic [ROW_BITS-1:0] row_r;
  logic [IDX_BITS-1:0] wr_idx_r;
  logic [KERNEL-1:0]   wr_sel_r;
  state_t              state_r;
  logic                col_wrap_s;
  logic                row_wrap_s;
  logic                idx_wrap_s;
  logic                line_end_s;
  logic                frame_end_s;

  assign line_end_s  = bus.data_valid & col_wrap_s;
  assign frame_end_s = line_end_s & row_wrap_s;

  wrap_counter #(.MOD(IMG_WIDTH), .W(COL_BITS)) u_col (
    .clock(clock), .reset(reset), .clr(1'b0), .en(bus.data_valid),
    .count(col_r), .wrap(col_wrap_s)
  );

  wrap_counter #(.MOD(IMG_HEIGHT), .W(ROW_BITS)) u_row (
    .clock(clock), .reset(reset), .clr(1'b0), .en(line_end_s),
    .count(row_r), .wrap(row_wrap_s)
  );

  // IMG_HEIGHT need not be a multiple of KERNEL, so the buffer index is forced home per frame.
  wrap_counter #(.MOD(KERNEL), .W(IDX_BITS)) u_idx (
    .clock(clock), .reset(reset), .clr(frame_end_s), .en(line_end_s),
    .count(wr_idx_r), .wrap(idx_wrap_s)
  );

  // Phase FSM, write-select rotation and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      wr_sel_r         <= KERNEL'(1);
      bus.window_valid <= 1'b0;
      bus.frame_done   <= 1'b0;
    end else begin
      bus.window_valid <= bus.data_valid && (state_r == STREAM) && (col_r >= COL_FIRST_WIN);
      bus.frame_done   <= frame_end_s;
      if (bus.data_valid) begin
        if (frame_end_s) begin
          state_r  <= IDLE;
          wr_sel_r <= KERNEL'(1);
        end else begin
          if (line_end_s) begin
            wr_sel_r <= {wr_sel_r[KERNEL-2:0], wr_sel_r[KERNEL-1]};
          end else begin
            wr_sel_r <= wr_sel_r;
          end
          case (state_r)
            IDLE:    state_r <= FILL;
            FILL:    state_r <= (line_end_s && (row_r == ROW_FILL_LAST)) ? STREAM : FILL;
            STREAM:  state_r <= STREAM;
            default: state_r <= IDLE;
          endcase
        end
      end else begin
        state_r  <= state_r;
        wr_sel_r <= wr_sel_r;
      end
    end
  end

  assign bus.buf_wr_en  = wr_sel_r & {KERNEL{bus.data_valid}};
  assign bus.wr_idx     = wr_idx_r;
  assign bus.rd_top_idx = idx_wrap_s ? {IDX_BITS{1'b0}} : wr_idx_r + IDX_BITS'(1);
  assign bus.rd_en      = bus.data_valid && (state_r == STREAM);
  assign bus.col_addr   = col_r;

endmodule
